top_cpu_0_cpu_mult_result: RTL and testbench

TOP_CPU_0_CPU_MULT_RESULT -- requirements
Module: top_cpu_0_cpu_mult_result

---
 rtl/top_cpu_0_cpu_mult_result_pkg.sv | 30 +++
 rtl/top_cpu_0_cpu_mult_hi16.sv | 62 ++++++
 rtl/top_cpu_0_cpu_mult_result.sv | 131 +++++++++++++
 tb/tb_top_cpu_0_cpu_mult_result.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/top_cpu_0_cpu_mult_result_pkg.sv
// Shared types and constants for the CPU multiply-result unit.
// Holds the op encodings, high-op FSM states and the 16-bit half width.
package top_cpu_0_cpu_mult_result_pkg;

  localparam int HALF_W   = 16;
  localparam int ITER_CNT = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } mul_state_e;

  // Low 32 bits of A*B assembled from the three partial-product cells.
  function automatic logic [31:0] low_word(input logic [31:0] p1,
                                           input logic [31:0] p2,
                                           input logic [31:0] p3);
    logic [31:0] mid;
    mid      = p2 + p3;
    low_word = p1 + (mid << HALF_W);
  endfunction

endpackage

// File: rtl/top_cpu_0_cpu_mult_hi16.sv
// 16x16 unsigned sequential multiplier, one shift-add step per cycle.
// start_i loads operands; done_o is high during the last of ITER_CNT steps, p_o is final the cycle after.
module top_cpu_0_cpu_mult_hi16
  import top_cpu_0_cpu_mult_result_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o,
  output logic        done_o
);

  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplr_q, mplr_d;
  logic [31:0] acc_q, acc_d;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = 4'd0;
      mcand_d = {16'b0, a_i};
      mplr_d  = b_i;
      acc_d   = 32'd0;
    end else if (busy_q) begin
      // Multiplicand shifts left as multiplier bits are consumed LSB first.
      acc_d   = acc_q + (mplr_q[0] ? mcand_q : 32'd0);
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == 4'(ITER_CNT - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      mcand_q <= 32'd0;
      mplr_q  <= 16'd0;
      acc_q   <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

  assign done_o = busy_q && (cnt_q == 4'(ITER_CNT - 1));
  assign p_o    = acc_q;

endmodule

// File: rtl/top_cpu_0_cpu_mult_result.sv
// M/W-stage multiply result unit: MUL low word in 1 cycle; MULX* high word in 18 cycles with M held via M_mul_stall.
// High ops exist only when TOP_CPU_0_CPU_MULX_EN is defined; otherwise every op returns the low word.
module top_cpu_0_cpu_mult_result
  import top_cpu_0_cpu_mult_result_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_en,
  input  logic        M_mul_start,
  input  logic [1:0]  M_mul_op,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic [31:0] W_mul_result,
  output logic        W_mul_valid,
  output logic        M_mul_stall
);

  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic [31:0] low_in;

  assign low_in = low_word(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);

`ifdef TOP_CPU_0_CPU_MULX_EN
  mul_state_e  state_q, state_d;
  mul_op_e     op_q;
  logic [31:0] a_q, b_q, p2_q, p3_q;
  logic [15:0] p1_hi_q;
  logic        accept, hi_start, hi_done;
  logic [31:0] p4, hu, h;
  logic [1:0]  carry;

  assign accept   = M_en && M_mul_start && (state_q == ST_IDLE);
  assign hi_start = accept && (mul_op_e'(M_mul_op) != OP_MUL);

  top_cpu_0_cpu_mult_hi16 u_hi16 (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (hi_start),
    .a_i     (M_src1[31:16]),
    .b_i     (M_src2[31:16]),
    .p_o     (p4),
    .done_o  (hi_done)
  );

  // Carry out of bits [31:16] of the full product, 0..2.
  assign carry = 2'(({2'b0, p1_hi_q} + {2'b0, p2_q[15:0]} + {2'b0, p3_q[15:0]}) >> HALF_W);
  assign hu    = p4 + {16'b0, p2_q[31:16]} + {16'b0, p3_q[31:16]} + {30'b0, carry};
  assign h     = hu - (((op_q != OP_MULXUU) && a_q[31]) ? b_q : 32'd0)
                    - (((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'd0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (mul_op_e'(M_mul_op) == OP_MUL) begin
            result_d = low_in;
            valid_d  = 1'b1;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: if (hi_done) state_d = ST_FIX;
      ST_FIX: begin
        result_d = h;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      p1_hi_q <= 16'd0;
      p2_q    <= 32'd0;
      p3_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= mul_op_e'(M_mul_op);
        a_q     <= M_src1;
        b_q     <= M_src2;
        p1_hi_q <= M_mul_cell_p1[31:16];
        p2_q    <= M_mul_cell_p2;
        p3_q    <= M_mul_cell_p3;
      end
    end
  end

  assign M_mul_stall = (state_q != ST_IDLE);
`else
  logic accept;
  logic unused_ok;

  assign accept    = M_en && M_mul_start;
  assign unused_ok = ^{M_mul_op, M_src1, M_src2};

  always_comb begin
    result_d = accept ? low_in : result_q;
    valid_d  = accept;
  end

  assign M_mul_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign W_mul_result = result_q;
  assign W_mul_valid  = valid_q;

endmodule

// File: tb/tb_top_cpu_0_cpu_mult_result.sv
// Directed bench for top_cpu_0_cpu_mult_result; expectations follow TOP_CPU_0_CPU_MULX_EN.
module tb_top_cpu_0_cpu_mult_result;
  import top_cpu_0_cpu_mult_result_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        M_en, M_mul_start;
  logic [1:0]  M_mul_op;
  logic [31:0] M_src1, M_src2;
  logic [31:0] M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3;
  logic [31:0] W_mul_result;
  logic        W_mul_valid, M_mul_stall;

  int checks   = 0;
  int failures = 0;

  top_cpu_0_cpu_mult_result dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_en          (M_en),
    .M_mul_start   (M_mul_start),
    .M_mul_op      (M_mul_op),
    .M_src1        (M_src1),
    .M_src2        (M_src2),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid),
    .M_mul_stall   (M_mul_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request with its partial-product cells; returns one cycle after the accepting edge.
  task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    M_en          = 1'b1;
    M_mul_start   = 1'b1;
    M_mul_op      = op;
    M_src1        = a;
    M_src2        = b;
    M_mul_cell_p1 = {16'b0, a[15:0]}  * {16'b0, b[15:0]};
    M_mul_cell_p2 = {16'b0, a[15:0]}  * {16'b0, b[31:16]};
    M_mul_cell_p3 = {16'b0, a[31:16]} * {16'b0, b[15:0]};
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    set_req(op, a, b);
    tick();
    M_mul_start = 1'b0;
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, prod;
    ea   = (op == OP_MULXSU || op == OP_MULXSS) ? {{32{a[31]}}, a} : {32'b0, a};
    eb   = (op == OP_MULXSS) ? {{32{b[31]}}, b} : {32'b0, b};
    prod = ea * eb;
    ref_mul = (op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  // Called one cycle after acceptance of a high op; walks to the valid cycle and checks it.
  task automatic run_hi(input string tag, input logic [31:0] exp);
    int stall_cnt = 0;
    int vcnt = 0;
    for (int k = 1; k <= 17; k++) begin
      if (M_mul_stall) stall_cnt++;
      if (W_mul_valid) vcnt++;
      tick();
    end
    check({tag, "_stall_cycles"}, stall_cnt, 17);
    check({tag, "_early_valid"}, vcnt, 0);
    check({tag, "_valid"}, {31'b0, W_mul_valid}, 1);
    check({tag, "_result"}, W_mul_result, exp);
    check({tag, "_stall_in_valid"}, {31'b0, M_mul_stall}, 0);
    tick();
    check({tag, "_valid_drop"}, {31'b0, W_mul_valid}, 0);
    check({tag, "_hold"}, W_mul_result, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    M_en = 1'b0; M_mul_start = 1'b0; M_mul_op = 2'b00;
    M_src1 = '0; M_src2 = '0;
    M_mul_cell_p1 = '0; M_mul_cell_p2 = '0; M_mul_cell_p3 = '0;
    tick(); tick();
    check("rst_result", W_mul_result, 0);
    check("rst_valid", {31'b0, W_mul_valid}, 0);
    check("rst_stall", {31'b0, M_mul_stall}, 0);
    reset_n = 1'b1;

    // MUL accepted on the first edge after reset release.
    issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    check("mul_valid", {31'b0, W_mul_valid}, 1);
    check("mul_result", W_mul_result, 32'h000B_000F);
    check("mul_stall", {31'b0, M_mul_stall}, 0);
    tick();
    check("mul_valid_drop", {31'b0, W_mul_valid}, 0);
    check("mul_hold", W_mul_result, 32'h000B_000F);

    // M_en low blocks acceptance.
    set_req(OP_MUL, 32'h0000_0007, 32'h0000_0009);
    M_en = 1'b0;
    tick();
    M_mul_start = 1'b0;
    check("en_low_valid", {31'b0, W_mul_valid}, 0);
    check("en_low_hold", W_mul_result, 32'h000B_000F);
    M_en = 1'b1;

`ifdef TOP_CPU_0_CPU_MULX_EN
    issue(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_hi("xuu_ones", 32'hFFFF_FFFE);
    issue(OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002);
    run_hi("xss_m1x2", 32'hFFFF_FFFF);
    issue(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_hi("xsu_ones", 32'hFFFF_FFFF);
    issue(OP_MULXSS, 32'h8000_0000, 32'h8000_0000);
    run_hi("xss_min", 32'h4000_0000);
    issue(OP_MULXSS, 32'h1234_5678, 32'h9ABC_DEF0);
    run_hi("xss_mixed", ref_mul(OP_MULXSS, 32'h1234_5678, 32'h9ABC_DEF0));
    issue(OP_MULXSU, 32'h8765_4321, 32'hFEDC_BA98);
    run_hi("xsu_mixed", ref_mul(OP_MULXSU, 32'h8765_4321, 32'hFEDC_BA98));

    // Second request while busy is ignored.
    begin
      int vcnt = 0;
      issue(OP_MULXUU, 32'h1234_5678, 32'h9ABC_DEF0);
      for (int k = 1; k <= 17; k++) begin
        if (k == 3) set_req(OP_MUL, 32'h0000_0002, 32'h0000_0003);
        else M_mul_start = 1'b0;
        if (W_mul_valid) vcnt++;
        tick();
      end
      M_mul_start = 1'b0;
      check("busy_early_valid", vcnt, 0);
      check("busy_valid", {31'b0, W_mul_valid}, 1);
      check("busy_result", W_mul_result, ref_mul(OP_MULXUU, 32'h1234_5678, 32'h9ABC_DEF0));
      vcnt = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (W_mul_valid) vcnt++;
      end
      check("busy_extra_valid", vcnt, 0);
    end

    // Reset mid-iteration discards the operation.
    begin
      int vcnt = 0;
      issue(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int k = 1; k < 8; k++) tick();
      reset_n = 1'b0;
      #1;
      check("midrst_result", W_mul_result, 0);
      check("midrst_valid", {31'b0, W_mul_valid}, 0);
      check("midrst_stall", {31'b0, M_mul_stall}, 0);
      tick(); tick();
      reset_n = 1'b1;
      issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
      check("postrst_valid", {31'b0, W_mul_valid}, 1);
      check("postrst_result", W_mul_result, 32'h000B_000F);
      for (int k = 0; k < 20; k++) begin
        tick();
        if (W_mul_valid) vcnt++;
        if (M_mul_stall) vcnt++;
      end
      check("postrst_quiet", vcnt, 0);
    end
`else
    issue(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nox_xuu_valid", {31'b0, W_mul_valid}, 1);
    check("nox_xuu_result", W_mul_result, 32'h0000_0001);
    check("nox_xuu_stall", {31'b0, M_mul_stall}, 0);
    issue(OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002);
    check("nox_xss_valid", {31'b0, W_mul_valid}, 1);
    check("nox_xss_result", W_mul_result, 32'hFFFF_FFFE);

    // Back-to-back requests each produce a result.
    set_req(OP_MUL, 32'h0000_0010, 32'h0000_0011);
    tick();
    check("nox_b2b0", W_mul_result, 32'h0000_0110);
    set_req(OP_MULXSU, 32'h0003_0000, 32'h0000_0004);
    tick();
    M_mul_start = 1'b0;
    check("nox_b2b1", W_mul_result, 32'h000C_0000);
    check("nox_b2b1_valid", {31'b0, W_mul_valid}, 1);
    tick();
    check("nox_idle_valid", {31'b0, W_mul_valid}, 0);
    check("nox_idle_stall", {31'b0, M_mul_stall}, 0);

    reset_n = 1'b0;
    #1;
    check("nox_rst_result", W_mul_result, 0);
    tick();
    reset_n = 1'b1;
    issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    check("nox_postrst_result", W_mul_result, 32'h000B_000F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
